// File: rtl/commit_perf_monitor.sv
// commit_perf_monitor
//   Watches the CPU debug commit interface, counts cycles / retired
//   instructions / per-class instructions while running, freezes everything
//   when a configurable stop PC commits, and buffers a (PC, instruction)
//   commit trace in a FIFO drained by an on-chip reader.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   enable_i, clear_i       run/pause request, synchronous clear to IDLE
//   stop_pc_i               PC whose commit ends measurement
//   commit_*_i              commit strobe, PC and instruction word
//   *_count_o               saturating event counters (registered)
//   state_o, done_o         00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   trace_*                 FIFO head with valid/ready pop, sticky overflow
module commit_perf_monitor #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [ADDR_WIDTH-1:0] stop_pc_i,
    input  logic                  commit_valid_i,
    input  logic [ADDR_WIDTH-1:0] commit_pc_i,
    input  logic [DATA_WIDTH-1:0] commit_instr_i,
    output logic [CNT_WIDTH-1:0]  cycle_count_o,
    output logic [CNT_WIDTH-1:0]  instr_count_o,
    output logic [CNT_WIDTH-1:0]  load_count_o,
    output logic [CNT_WIDTH-1:0]  store_count_o,
    output logic [CNT_WIDTH-1:0]  branch_count_o,
    output logic [CNT_WIDTH-1:0]  dropped_count_o,
    output logic [1:0]            state_o,
    output logic                  done_o,
    output logic                  trace_valid_o,
    input  logic                  trace_ready_i,
    output logic [ADDR_WIDTH-1:0] trace_pc_o,
    output logic [DATA_WIDTH-1:0] trace_instr_o,
    output logic                  trace_overflow_o
);

    localparam int PTR_W = $clog2(TRACE_DEPTH);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [PTR_W:0]       PTR_ONE = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next
        // unassigned and no latch is inferred.
        state_next = state;
        if (clear_i) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (enable_i) state_next = RUN;
                RUN: begin
                    // The stop commit wins over a simultaneous pause request.
                    if (commit_valid_i && (commit_pc_i == stop_pc_i)) state_next = DONE;
                    else if (!enable_i)                               state_next = PAUSE;
                end
                PAUSE:   if (enable_i) state_next = RUN;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    assign state_o = state;
    assign done_o  = (state == DONE);

    // ------------------------------------------------------------------
    // Commit acceptance and trace FIFO control
    // ------------------------------------------------------------------
    logic [6:0]     opcode;
    logic           accept;
    logic [PTR_W:0] wr_ptr, rd_ptr;
    logic           fifo_empty, fifo_full, do_pop, do_push, do_drop;

    assign opcode = commit_instr_i[6:0];
    assign accept = (state == RUN) && commit_valid_i && !clear_i;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop     = !fifo_empty && trace_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push    = accept && (!fifo_full || do_pop);
    assign do_drop    = accept && fifo_full && !do_pop;

    logic [ADDR_WIDTH-1:0] pc_mem    [TRACE_DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem [TRACE_DEPTH];

    // NOTE: the storage array carries no reset; the pointers alone decide
    // which entries are valid, so it maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            pc_mem[wr_ptr[PTR_W-1:0]]    <= commit_pc_i;
            instr_mem[wr_ptr[PTR_W-1:0]] <= commit_instr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            trace_overflow_o <= 1'b0;
            dropped_count_o  <= '0;
        end else if (clear_i) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            trace_overflow_o <= 1'b0;
            dropped_count_o  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_drop) begin
                trace_overflow_o <= 1'b1;
                dropped_count_o  <= sat_inc(dropped_count_o);
            end
        end
    end

    // Head read straight from storage: data appears the cycle after the push
    // and stays put until popped. Forced to zero while empty.
    assign trace_valid_o = !fifo_empty;
    assign trace_pc_o    = fifo_empty ? '0 : pc_mem[rd_ptr[PTR_W-1:0]];
    assign trace_instr_o = fifo_empty ? '0 : instr_mem[rd_ptr[PTR_W-1:0]];

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_count_o  <= '0;
            instr_count_o  <= '0;
            load_count_o   <= '0;
            store_count_o  <= '0;
            branch_count_o <= '0;
        end else if (clear_i) begin
            cycle_count_o  <= '0;
            instr_count_o  <= '0;
            load_count_o   <= '0;
            store_count_o  <= '0;
            branch_count_o <= '0;
        end else begin
            if (state == RUN) cycle_count_o <= sat_inc(cycle_count_o);
            if (accept) begin
                instr_count_o <= sat_inc(instr_count_o);
                if (opcode == OP_LOAD)  load_count_o  <= sat_inc(load_count_o);
                if (opcode == OP_STORE) store_count_o <= sat_inc(store_count_o);
                if ((opcode == OP_BRANCH) || (opcode == OP_JAL))
                    branch_count_o <= sat_inc(branch_count_o);
            end
        end
    end

endmodule

// File: tb/tb_commit_perf_monitor.sv
// tb_commit_perf_monitor
//   Directed scenarios plus randomized traffic for commit_perf_monitor,
//   compared every cycle against a queue-based behavioural model.
//   Counters are narrowed to 8 bits so saturation is reached in the run.
module tb_commit_perf_monitor;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = 8;
    localparam int DEPTH = 16;
    localparam longint CMAX = (64'd1 << CW) - 1;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          enable_i = 1'b0;
    logic          clear_i = 1'b0;
    logic [AW-1:0] stop_pc_i = 32'hFFFF_FFFC;
    logic          commit_valid_i = 1'b0;
    logic [AW-1:0] commit_pc_i = '0;
    logic [DW-1:0] commit_instr_i = '0;
    logic [CW-1:0] cycle_count_o, instr_count_o, load_count_o;
    logic [CW-1:0] store_count_o, branch_count_o, dropped_count_o;
    logic [1:0]    state_o;
    logic          done_o, trace_valid_o, trace_overflow_o;
    logic          trace_ready_i = 1'b0;
    logic [AW-1:0] trace_pc_o;
    logic [DW-1:0] trace_instr_o;

    commit_perf_monitor #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .clear_i(clear_i),
        .stop_pc_i(stop_pc_i), .commit_valid_i(commit_valid_i),
        .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i),
        .cycle_count_o(cycle_count_o), .instr_count_o(instr_count_o),
        .load_count_o(load_count_o), .store_count_o(store_count_o),
        .branch_count_o(branch_count_o), .dropped_count_o(dropped_count_o),
        .state_o(state_o), .done_o(done_o), .trace_valid_o(trace_valid_o),
        .trace_ready_i(trace_ready_i), .trace_pc_o(trace_pc_o),
        .trace_instr_o(trace_instr_o), .trace_overflow_o(trace_overflow_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] instr;
    } entry_t;

    entry_t q[$];
    int     m_state;  // 0 idle, 1 run, 2 pause, 3 done
    longint m_cyc, m_instr, m_load, m_store, m_branch, m_drop;
    bit     m_ovf;

    function automatic longint sat(input longint v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_state = 0;
        m_cyc = 0; m_instr = 0; m_load = 0; m_store = 0; m_branch = 0; m_drop = 0;
        m_ovf = 0;
    endtask

    // One rising edge, using the inputs currently applied.
    task automatic model_step();
        bit pop, acc, drop;
        logic [6:0] op;
        entry_t e;
        if (rst_i || clear_i) begin
            model_reset();
            return;
        end
        pop  = (q.size() > 0) && trace_ready_i;
        acc  = (m_state == 1) && commit_valid_i;
        drop = acc && (q.size() == DEPTH) && !pop;
        op   = commit_instr_i[6:0];
        if (m_state == 1) m_cyc = sat(m_cyc);
        if (acc) begin
            m_instr = sat(m_instr);
            if (op == OP_LW) m_load = sat(m_load);
            if (op == OP_SW) m_store = sat(m_store);
            if (op == OP_BEQ || op == OP_JAL) m_branch = sat(m_branch);
        end
        if (drop) begin
            m_drop = sat(m_drop);
            m_ovf  = 1;
        end
        if (pop) void'(q.pop_front());
        if (acc && !drop) begin
            e.pc = commit_pc_i;
            e.instr = commit_instr_i;
            q.push_back(e);
        end
        case (m_state)
            0: if (enable_i) m_state = 1;
            1: if (commit_valid_i && commit_pc_i == stop_pc_i) m_state = 3;
               else if (!enable_i) m_state = 2;
            2: if (enable_i) m_state = 1;
            default: m_state = 3;
        endcase
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},  state_o,          m_state);
        check({tag, ".done"},   done_o,           m_state == 3);
        check({tag, ".cycle"},  cycle_count_o,    m_cyc);
        check({tag, ".instr"},  instr_count_o,    m_instr);
        check({tag, ".load"},   load_count_o,     m_load);
        check({tag, ".store"},  store_count_o,    m_store);
        check({tag, ".branch"}, branch_count_o,   m_branch);
        check({tag, ".drop"},   dropped_count_o,  m_drop);
        check({tag, ".ovf"},    trace_overflow_o, m_ovf);
        check({tag, ".tvalid"}, trace_valid_o,    q.size() > 0);
        check({tag, ".tpc"},    trace_pc_o,       (q.size() > 0) ? q[0].pc : '0);
        check({tag, ".tinstr"}, trace_instr_o,    (q.size() > 0) ? q[0].instr : '0);
    endtask

    // Model the edge, wait for it, then compare 1 time unit later.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive_commit(input logic [AW-1:0] pc, input logic [6:0] op);
        logic [24:0] hi;
        hi = 25'($urandom);
        commit_valid_i = 1'b1;
        commit_pc_i    = pc;
        commit_instr_i = {hi, op};
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        commit_valid_i = 1'b0;
        tick("clear");
        clear_i = 1'b0;
    endtask

    function automatic logic [6:0] rand_op();
        logic [6:0] r;
        case ($urandom_range(0, 5))
            0: r = OP_ADD;
            1: r = OP_LW;
            2: r = OP_SW;
            3: r = OP_BEQ;
            4: r = OP_JAL;
            default: r = 7'($urandom);
        endcase
        return r;
    endfunction

    initial begin
        logic [6:0] ops [5];
        longint     held_cyc, held_instr;

        // Reset state
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Five mixed commits, no reader
        ops = '{OP_ADD, OP_LW, OP_SW, OP_BEQ, OP_JAL};
        enable_i = 1'b1;
        tick("t1_start");
        for (int i = 0; i < 5; i++) begin
            drive_commit(AW'(i * 4), ops[i]);
            tick("t1");
        end
        commit_valid_i = 1'b0;
        tick("t1_idle");
        check("t1_instr", instr_count_o, 5);
        check("t1_load", load_count_o, 1);
        check("t1_store", store_count_o, 1);
        check("t1_branch", branch_count_o, 2);
        check("t1_head", trace_pc_o, 0);

        // Stop PC after 40 RUN cycles
        do_clear();
        stop_pc_i = 32'h0000_00E4;
        tick("t2_start");
        for (int i = 0; i < 39; i++) tick("t2_run");
        drive_commit(32'hE4, OP_ADD);
        tick("t2_stop");
        commit_valid_i = 1'b0;
        check("t2_done", done_o, 1);
        check("t2_state", state_o, 2'b11);
        check("t2_cycle", cycle_count_o, 40);
        for (int i = 0; i < 6; i++) begin
            drive_commit(AW'(i * 4), OP_LW);
            enable_i = i[0];
            tick("t2_frozen");
        end
        commit_valid_i = 1'b0;
        enable_i = 1'b1;
        check("t2_cycle_hold", cycle_count_o, 40);
        check("t2_instr_hold", instr_count_o, 1);

        // 18 commits into a 16-deep FIFO, then drain
        do_clear();
        stop_pc_i = 32'hFFFF_FFFC;
        tick("t3_start");
        for (int i = 0; i < 18; i++) begin
            drive_commit(AW'(32'h100 + i * 4), OP_ADD);
            tick("t3_fill");
        end
        commit_valid_i = 1'b0;
        check("t3_drop", dropped_count_o, 2);
        check("t3_ovf", trace_overflow_o, 1);
        trace_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_drain_valid", trace_valid_o, 1);
            check("t3_drain_pc", trace_pc_o, 32'h100 + i * 4);
            tick("t3_drain");
        end
        check("t3_empty", trace_valid_o, 0);
        trace_ready_i = 1'b0;

        // Full FIFO, push and pop in the same cycle
        do_clear();
        tick("t4_start");
        for (int i = 0; i < 16; i++) begin
            drive_commit(AW'(32'h200 + i * 4), OP_SW);
            tick("t4_fill");
        end
        drive_commit(32'h300, OP_SW);
        trace_ready_i = 1'b1;
        tick("t4_both");
        commit_valid_i = 1'b0;
        trace_ready_i = 1'b0;
        check("t4_nodrop", dropped_count_o, 0);
        check("t4_head", trace_pc_o, 32'h204);
        check("t4_size", q.size() == 16 && q[15].pc == 32'h300, 1);

        // Pause with commits pulsed
        do_clear();
        tick("t5_start");
        for (int i = 0; i < 3; i++) begin
            drive_commit(AW'(32'h400 + i * 4), OP_BEQ);
            tick("t5_run");
        end
        commit_valid_i = 1'b0;
        enable_i = 1'b0;
        tick("t5_to_pause");
        held_cyc = m_cyc;
        held_instr = m_instr;
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 5 || i == 8) drive_commit(AW'(32'h500 + i * 4), OP_LW);
            else commit_valid_i = 1'b0;
            tick("t5_pause");
        end
        commit_valid_i = 1'b0;
        check("t5_state", state_o, 2'b10);
        check("t5_cycle", cycle_count_o, held_cyc);
        check("t5_instr", instr_count_o, held_instr);
        enable_i = 1'b1;
        tick("t5_resume");

        // Asynchronous reset with 7 entries queued
        do_clear();
        tick("t6_start");
        for (int i = 0; i < 7; i++) begin
            drive_commit(AW'(32'h600 + i * 4), OP_JAL);
            tick("t6_fill");
        end
        commit_valid_i = 1'b0;
        #3;
        rst_i = 1'b1;
        #1;
        check("t6_async_valid", trace_valid_o, 0);
        check("t6_async_instr", instr_count_o, 0);
        check("t6_async_state", state_o, 0);
        model_reset();
        check_all("t6_async");
        tick("t6_held");
        rst_i = 1'b0;

        // clear in DONE
        stop_pc_i = 32'h40;
        tick("t7_start");
        drive_commit(32'h40, OP_ADD);
        tick("t7_stop");
        commit_valid_i = 1'b0;
        check("t7_done", done_o, 1);
        clear_i = 1'b1;
        tick("t7_clear");
        clear_i = 1'b0;
        check("t7_state", state_o, 0);
        check("t7_instr", instr_count_o, 0);
        check("t7_cycle", cycle_count_o, 0);
        check("t7_valid", trace_valid_o, 0);

        // Randomized traffic
        stop_pc_i = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        for (int i = 0; i < 3000; i++) begin
            enable_i      = ($urandom_range(0, 9) != 0);
            clear_i       = ($urandom_range(0, 299) == 0);
            trace_ready_i = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1)
                drive_commit({24'd0, 6'($urandom_range(0, 63)), 2'b00}, rand_op());
            else
                commit_valid_i = 1'b0;
            if ($urandom_range(0, 199) == 0)
                stop_pc_i = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
